// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: two-port round-robin command arbiter and sequencer
// in front of the SPI master.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   reqN_i                   request level, held until ackN_o/errN_o
//   reqN_wr_i                1 = write, 0 = read (sampled at grant)
//   reqN_addr_i/wdata_i      address / write data (sampled at grant)
//   ackN_o, errN_o           one-cycle completion / failure pulses
//   rd_data_o                last successful read result
//   gnt_o                    one-hot owner, 00 when idle
//   busy_o                   high outside IDLE
//   spi_cmd_o                {WR_START, RD_START} one-cycle pulse
//   spi_addr_o, spi_wdata_o  latched command fields to the master
//   spi_wr_done_i/rd_done_i  completion strobes from the master
//   spi_rd_data_i            master read data, valid with rd_done
module spi_req_arbiter #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       req0_wr_i,
  input  logic       req1_wr_i,
  input  logic [6:0] req0_addr_i,
  input  logic [6:0] req1_addr_i,
  input  logic [7:0] req0_wdata_i,
  input  logic [7:0] req1_wdata_i,
  output logic       ack0_o,
  output logic       ack1_o,
  output logic       err0_o,
  output logic       err1_o,
  output logic [7:0] rd_data_o,
  output logic [1:0] gnt_o,
  output logic       busy_o,
  output logic [1:0] spi_cmd_o,
  output logic [6:0] spi_addr_o,
  output logic [7:0] spi_wdata_o,
  input  logic       spi_wr_done_i,
  input  logic       spi_rd_done_i,
  input  logic [7:0] spi_rd_data_i
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    GAP
  } state_e;

  state_e        state_q;
  logic          last_q;
  logic          own_q;
  logic          op_wr_q;
  logic [TW-1:0] tmo_q;
  logic [GW-1:0] gap_q;
  logic          ack0_q;
  logic          ack1_q;
  logic          err0_q;
  logic          err1_q;
  logic [7:0]    rd_data_q;
  logic [1:0]    gnt_q;
  logic          busy_q;
  logic [1:0]    cmd_q;
  logic [6:0]    addr_q;
  logic [7:0]    wdata_q;

  logic       win_d;
  logic       wr_d;
  logic [6:0] addr_d;
  logic [7:0] wdata_d;
  logic       done_d;
  logic       ok_d;

  // Tie goes to the requester that was not granted last.
  always_comb begin
    win_d = 1'b0;
    if (req0_i && req1_i) begin
      win_d = ~last_q;
    end else if (req1_i) begin
      win_d = 1'b1;
    end
    wr_d    = win_d ? req1_wr_i    : req0_wr_i;
    addr_d  = win_d ? req1_addr_i  : req0_addr_i;
    wdata_d = win_d ? req1_wdata_i : req0_wdata_i;
  end

  // Both strobes together never match a single op.
  assign done_d = spi_wr_done_i | spi_rd_done_i;
  assign ok_d   = op_wr_q ? (spi_wr_done_i & ~spi_rd_done_i)
                          : (spi_rd_done_i & ~spi_wr_done_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      own_q     <= 1'b0;
      op_wr_q   <= 1'b0;
      tmo_q     <= '0;
      gap_q     <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rd_data_q <= 8'h00;
      gnt_q     <= 2'b00;
      busy_q    <= 1'b0;
      cmd_q     <= 2'b00;
      addr_q    <= 7'h00;
      wdata_q   <= 8'h00;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      cmd_q  <= 2'b00;
      unique case (state_q)
        IDLE: begin
          if (req0_i || req1_i) begin
            own_q   <= win_d;
            last_q  <= win_d;
            op_wr_q <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            gnt_q   <= win_d ? 2'b10 : 2'b01;
            cmd_q   <= wr_d ? 2'b10 : 2'b01;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (done_d || tmo_q == TMO_LAST) begin
            // Done beats a timeout landing on the same cycle.
            if (done_d && ok_d) begin
              ack0_q <= ~own_q;
              ack1_q <= own_q;
              if (!op_wr_q) begin
                rd_data_q <= spi_rd_data_i;
              end
            end else begin
              err0_q <= ~own_q;
              err1_q <= own_q;
            end
            gnt_q   <= 2'b00;
            gap_q   <= '0;
            state_q <= GAP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign ack0_o      = ack0_q;
  assign ack1_o      = ack1_q;
  assign err0_o      = err0_q;
  assign err1_o      = err1_q;
  assign rd_data_o   = rd_data_q;
  assign gnt_o       = gnt_q;
  assign busy_o      = busy_q;
  assign spi_cmd_o   = cmd_q;
  assign spi_addr_o  = addr_q;
  assign spi_wdata_o = wdata_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter: directed stimulus with a timestamp-based
// reference model checked against the DUT every cycle.
module tb_spi_req_arbiter;

  localparam int TMO = 16;
  localparam int GAP = 4;

  logic       clk;
  logic       rst_i;
  logic       req0_i, req1_i;
  logic       req0_wr_i, req1_wr_i;
  logic [6:0] req0_addr_i, req1_addr_i;
  logic [7:0] req0_wdata_i, req1_wdata_i;
  logic       ack0_o, ack1_o, err0_o, err1_o;
  logic [7:0] rd_data_o;
  logic [1:0] gnt_o;
  logic       busy_o;
  logic [1:0] spi_cmd_o;
  logic [6:0] spi_addr_o;
  logic [7:0] spi_wdata_o;
  logic       spi_wr_done_i, spi_rd_done_i;
  logic [7:0] spi_rd_data_i;

  spi_req_arbiter #(.TIMEOUT(TMO), .GAP_CYC(GAP)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req0_i(req0_i), .req1_i(req1_i),
    .req0_wr_i(req0_wr_i), .req1_wr_i(req1_wr_i),
    .req0_addr_i(req0_addr_i), .req1_addr_i(req1_addr_i),
    .req0_wdata_i(req0_wdata_i), .req1_wdata_i(req1_wdata_i),
    .ack0_o(ack0_o), .ack1_o(ack1_o),
    .err0_o(err0_o), .err1_o(err1_o),
    .rd_data_o(rd_data_o), .gnt_o(gnt_o), .busy_o(busy_o),
    .spi_cmd_o(spi_cmd_o), .spi_addr_o(spi_addr_o),
    .spi_wdata_o(spi_wdata_o),
    .spi_wr_done_i(spi_wr_done_i), .spi_rd_done_i(spi_rd_done_i),
    .spi_rd_data_i(spi_rd_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Reference model: each transaction is described by its grant edge g,
  // the edge it ended on, and the edge from which requests are seen again.
  int         cyc = 0;
  bit         m_in = 0;
  int         m_g = 0;
  int         m_free = 0;
  bit         m_own = 0;
  bit         m_last = 1;
  bit         m_wr = 0;
  logic [6:0] m_addr = 0;
  logic [7:0] m_wdata = 0;
  logic [7:0] m_rd = 0;
  bit [1:0]   e_ack = 0;
  bit [1:0]   e_err = 0;
  logic [1:0] e_cmd = 0;

  task automatic model_step();
    bit wd, rd, ok;
    cyc++;
    e_ack = 0;
    e_err = 0;
    e_cmd = 0;
    wd = spi_wr_done_i;
    rd = spi_rd_done_i;
    if (rst_i) begin
      m_in = 0; m_free = cyc + 1; m_last = 1;
      m_rd = 0; m_addr = 0; m_wdata = 0;
    end else if (m_in) begin
      if (cyc >= m_g + 2 && (wd || rd || cyc == m_g + 1 + TMO)) begin
        ok = m_wr ? (wd && !rd) : (rd && !wd);
        if ((wd || rd) && ok) begin
          e_ack[m_own] = 1;
          if (!m_wr) m_rd = spi_rd_data_i;
        end else begin
          e_err[m_own] = 1;
        end
        m_in = 0;
        m_free = cyc + GAP + 1;
      end
    end else if (cyc >= m_free && (req0_i || req1_i)) begin
      m_own = (req0_i && req1_i) ? !m_last : req1_i;
      m_last = m_own;
      m_wr = m_own ? req1_wr_i : req0_wr_i;
      m_addr = m_own ? req1_addr_i : req0_addr_i;
      m_wdata = m_own ? req1_wdata_i : req0_wdata_i;
      m_g = cyc;
      m_in = 1;
      e_cmd = m_wr ? 2'b10 : 2'b01;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      chk("ack0", ack0_o, e_ack[0]);
      chk("ack1", ack1_o, e_ack[1]);
      chk("err0", err0_o, e_err[0]);
      chk("err1", err1_o, e_err[1]);
      chk("rd_data", rd_data_o, m_rd);
      chk("gnt", gnt_o, m_in ? (m_own ? 2'b10 : 2'b01) : 2'b00);
      chk("busy", busy_o, (m_in || cyc < m_free - 1));
      chk("cmd", spi_cmd_o, e_cmd);
      if (m_in) begin
        chk("addr", spi_addr_o, m_addr);
        chk("wdata", spi_wdata_o, m_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_cmd(output int at);
    int n;
    n = 0;
    while (spi_cmd_o == 2'b00 && n < 200) begin
      tick();
      n++;
    end
    chk("cmd_seen", (n < 200), 1);
    at = cyc;
  endtask

  task automatic set_req(input int p, input bit wr,
                         input logic [6:0] a, input logic [7:0] d);
    if (p == 0) begin
      req0_i = 1; req0_wr_i = wr; req0_addr_i = a; req0_wdata_i = d;
    end else begin
      req1_i = 1; req1_wr_i = wr; req1_addr_i = a; req1_wdata_i = d;
    end
  endtask

  int g, dn, prev_d;

  initial begin
    rst_i = 1;
    req0_i = 0; req1_i = 0;
    req0_wr_i = 0; req1_wr_i = 0;
    req0_addr_i = 0; req1_addr_i = 0;
    req0_wdata_i = 0; req1_wdata_i = 0;
    spi_wr_done_i = 0; spi_rd_done_i = 0; spi_rd_data_i = 0;
    ticks(3);
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_busy", busy_o, 0);
    chk("rst_rd", rd_data_o, 8'h00);
    chk("rst_cmd", spi_cmd_o, 2'b00);
    rst_i = 0;
    tick();

    // single write from requester 0
    set_req(0, 1, 7'h12, 8'hA5);
    wait_cmd(g);
    chk("w_cmd", spi_cmd_o, 2'b10);
    chk("w_addr", spi_addr_o, 7'h12);
    chk("w_wdata", spi_wdata_o, 8'hA5);
    chk("w_gnt", gnt_o, 2'b01);
    tick();
    chk("w_cmd_1cyc", spi_cmd_o, 2'b00);
    ticks(11);
    spi_wr_done_i = 1;
    tick();
    spi_wr_done_i = 0;
    chk("w_ack0", ack0_o, 1);
    chk("w_gnt_clr", gnt_o, 2'b00);
    req0_i = 0;
    ticks(GAP - 1);
    chk("w_gap_busy", busy_o, 1);
    tick();
    chk("w_idle", busy_o, 0);

    // single read from requester 1
    set_req(1, 0, 7'h05, 8'h00);
    wait_cmd(g);
    chk("r_cmd", spi_cmd_o, 2'b01);
    chk("r_gnt", gnt_o, 2'b10);
    ticks(5);
    spi_rd_done_i = 1;
    spi_rd_data_i = 8'h3C;
    tick();
    spi_rd_done_i = 0;
    spi_rd_data_i = 8'h00;
    chk("r_ack1", ack1_o, 1);
    chk("r_data", rd_data_o, 8'h3C);
    req1_i = 0;

    // a write must not disturb RD_DATA
    set_req(0, 1, 7'h21, 8'h5A);
    wait_cmd(g);
    ticks(3);
    spi_wr_done_i = 1;
    spi_rd_data_i = 8'hEE;
    tick();
    spi_wr_done_i = 0;
    chk("w2_ack0", ack0_o, 1);
    chk("w2_rd_hold", rd_data_o, 8'h3C);
    req0_i = 0;

    // timeout on a read
    set_req(0, 0, 7'h07, 8'h00);
    wait_cmd(g);
    ticks(TMO);
    chk("t_no_err_early", err0_o, 0);
    tick();
    chk("t_err0", err0_o, 1);
    chk("t_no_ack", ack0_o, 0);
    chk("t_rd_hold", rd_data_o, 8'h3C);
    req0_i = 0;

    // done type mismatch
    set_req(0, 1, 7'h33, 8'h44);
    wait_cmd(g);
    ticks(2);
    spi_rd_done_i = 1;
    spi_rd_data_i = 8'hEE;
    tick();
    spi_rd_done_i = 0;
    chk("m_err0", err0_o, 1);
    chk("m_no_ack", ack0_o, 0);
    chk("m_rd_hold", rd_data_o, 8'h3C);
    req0_i = 0;

    // both done strobes together
    set_req(1, 0, 7'h09, 8'h00);
    wait_cmd(g);
    tick();
    spi_rd_done_i = 1;
    spi_wr_done_i = 1;
    tick();
    spi_rd_done_i = 0;
    spi_wr_done_i = 0;
    chk("b_err1", err1_o, 1);
    chk("b_rd_hold", rd_data_o, 8'h3C);
    req1_i = 0;

    // done on the last timeout cycle wins
    set_req(0, 1, 7'h40, 8'h01);
    wait_cmd(g);
    ticks(TMO);
    spi_wr_done_i = 1;
    tick();
    spi_wr_done_i = 0;
    chk("c_ack0", ack0_o, 1);
    chk("c_no_err", err0_o, 0);
    req0_i = 0;

    // reset mid-WAIT, then ties alternate starting at 0
    set_req(0, 1, 7'h22, 8'h99);
    wait_cmd(g);
    ticks(3);
    rst_i = 1;
    tick();
    chk("x_gnt", gnt_o, 2'b00);
    chk("x_busy", busy_o, 0);
    chk("x_ack", {ack1_o, ack0_o}, 2'b00);
    chk("x_err", {err1_o, err0_o}, 2'b00);
    chk("x_cmd", spi_cmd_o, 2'b00);
    chk("x_rd", rd_data_o, 8'h00);
    rst_i = 0;
    set_req(1, 1, 7'h44, 8'h11);
    prev_d = -1;
    for (int i = 0; i < 4; i++) begin
      wait_cmd(g);
      chk("tie_gnt", gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("tie_addr", spi_addr_o, (i % 2 == 0) ? 7'h22 : 7'h44);
      if (prev_d >= 0) chk("tie_space", g - prev_d, GAP + 1);
      ticks(2);
      spi_wr_done_i = 1;
      tick();
      spi_wr_done_i = 0;
      dn = cyc;
      chk("tie_ack", {ack1_o, ack0_o},
          (i % 2 == 0) ? 2'b01 : 2'b10);
      prev_d = dn;
    end
    req0_i = 0;
    req1_i = 0;
    ticks(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
